afifo_write_arbiter: RTL and testbench
======================================

AFIFO_WRITE_ARBITER -- requirements
Module: afifo_write_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  DataSize, 3, FIFO data width
  NumReq, 4, requester count (power of 2, at least 2)
  MaxBurst, 4, maximum consecutive pushes per grant (at least 1)
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  Wclk, in, 1, write-domain clock; all logic rises on posedge
  Wresetn, in, 1, asynchronous active-low reset
  ReqValid, in, NumReq, per-requester data valid
  ReqData, in, NumReq*DataSize, packed requester data; requester i occupies bits [i*DataSize +: DataSize]
  ReqReady, out, NumReq, per-requester accept strobe
  full, in, 1, FIFO write-side full flag
  Push, out, 1, FIFO write strobe
  DataIn, out, DataSize, FIFO write data
  GrantId, out, $clog2(NumReq), index of the current grant holder
  Busy, out, 1, arbiter in BURST state
  StallCnt, out, 16, saturating count of full-blocked cycles
REQ-003 The single clock SHALL be Wclk; Wresetn SHALL be asynchronous and active-low.

Function
REQ-004 FSM SHALL have two states: IDLE and BURST; Busy = (state == BURST).
REQ-005 IDLE, any ReqValid high: latch the winner into GrantId, clear BurstCnt, and go to BURST next cycle. This gives 1 cycle of arbitration latency. No push occurs in IDLE.
REQ-006 Winner SHALL be the first requester with ReqValid high, searching (LastGrant+1) mod NumReq upward with wrap-around (round-robin).
REQ-007 In BURST: Push = ReqValid[GrantId] && !full, combinational.
REQ-008 DataIn SHALL equal ReqData slice GrantId, combinational, in every state.
REQ-009 ReqReady[i] = Push && (GrantId == i); no other bit SHALL be high. Acceptance and FIFO write SHALL occur in the same cycle.
REQ-010 On each Push, BurstCnt SHALL increment; BurstCnt width is $clog2(MaxBurst)+1.
REQ-011 BURST to IDLE SHALL occur when either:
  - ReqValid[GrantId] is low, or
  - a Push occurs with BurstCnt == MaxBurst-1.
  On exit, LastGrant <= GrantId.
REQ-012 BURST with ReqValid[GrantId] && full: hold state, Push = 0, BurstCnt unchanged, StallCnt += 1 (saturating at 16'hFFFF).
REQ-013 A requester dropping ReqValid while blocked by full SHALL cause exit per REQ-011 with no push.
REQ-014 Requests arriving in other slots during BURST SHALL wait; no preemption.
REQ-015 MaxBurst = 1 SHALL give exactly one push per grant and a strict IDLE/BURST alternation under continuous load.
REQ-016 Push SHALL never assert while full = 1.
REQ-017 ReqReady and Push SHALL never assert in IDLE.

Reset
REQ-018 On Wresetn low, asynchronously:
  - state = IDLE
  - GrantId = 0, BurstCnt = 0, StallCnt = 0
  - LastGrant = NumReq-1, so requester 0 wins first
  - Push = 0, ReqReady = 0, Busy = 0
REQ-019 Reset asserted mid-burst SHALL abort the burst without a push in the reset cycle. After release, arbitration SHALL restart from requester 0.
REQ-020 Outputs SHALL become valid on the first Wclk edge after Wresetn deasserts; no extra synchronizer stages.

Verification
REQ-021 Sequence: reset, then ReqValid=4'b0001 held, full=0, ReqData0 = 1..6.
  -> IDLE 1 cycle, pushes 1,2,3,4, IDLE 1 cycle, then pushes 5,6.
  -> GrantId=0 throughout; StallCnt=0.
REQ-022 ReqValid=4'b1111 continuous, full=0.
  -> Grants SHALL be 0,1,2,3,0 in order.
  -> Each grant gives 4 pushes then 1 IDLE cycle (5-cycle period).
REQ-023 Grant=2, full=1 for 7 cycles mid-burst.
  -> Push=0 and ReqReady=0 for those 7 cycles; StallCnt=7.
  -> Burst resumes with the remaining count after full drops.
REQ-024 full held 1, StallCnt preloaded near max via a long stall of at least 65540 cycles.
  -> StallCnt SHALL stick at 16'hFFFF.
REQ-025 Wresetn pulsed low during the push of a burst on requester 3.
  -> Push=0 immediately; all outputs at reset values.
  -> After release with ReqValid=4'b1000, GrantId=3 is reached only after requesters 0-2 are skipped (idle), one arbitration cycle.
REQ-026 Assertions SHALL be bound:
  - Push implies !full
  - $onehot0(ReqReady)
  - ReqReady implies Busy
  - at most MaxBurst consecutive ReqReady pulses on one index

Source files
------------

// File: rtl/afifo_write_arbiter_if.sv
// Requester-side and FIFO write-side signals of the FIFO write arbiter.
// The arbiter uses the slave modport; whatever drives requests and the full flag uses master.
interface afifo_write_arbiter_if #(
  parameter int DataSize = 3,
  parameter int NumReq   = 4
);
  localparam int GrantW = $clog2(NumReq);

  logic [NumReq-1:0]          ReqValid;
  logic [NumReq*DataSize-1:0] ReqData;
  logic [NumReq-1:0]          ReqReady;
  logic                       full;
  logic                       Push;
  logic [DataSize-1:0]        DataIn;
  logic [GrantW-1:0]          GrantId;
  logic                       Busy;
  logic [15:0]                StallCnt;

  modport master (
    output ReqValid, ReqData, full,
    input  ReqReady, Push, DataIn, GrantId, Busy, StallCnt
  );

  modport slave (
    input  ReqValid, ReqData, full,
    output ReqReady, Push, DataIn, GrantId, Busy, StallCnt
  );
endinterface

// File: rtl/afifo_write_arbiter.sv
// Round-robin arbiter feeding the write side of a FIFO; a grant holds for up to
// MaxBurst pushes, stalls on full, and releases when its requester drops valid.
module afifo_write_arbiter #(
  parameter int DataSize = 3,
  parameter int NumReq   = 4,
  parameter int MaxBurst = 4
) (
  input  logic                  Wclk,
  input  logic                  Wresetn,
  afifo_write_arbiter_if.slave  bus
);

  localparam int GrantW = $clog2(NumReq);
  localparam int BurstW = $clog2(MaxBurst) + 1;
  localparam logic [BurstW-1:0] LastBeat = BurstW'(MaxBurst - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [GrantW-1:0]   grant_q, grant_d;
  logic [GrantW-1:0]   last_q, last_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic [15:0]         stall_q, stall_d;
  logic [GrantW-1:0]   winner;
  logic                win_found;
  logic                sel_valid;
  logic                push;
  logic [DataSize-1:0] req_slice [NumReq];

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_req
      assign req_slice[gi]    = bus.ReqData[gi*DataSize +: DataSize];
      assign bus.ReqReady[gi] = push && (grant_q == GrantW'(gi));
    end
  endgenerate

  // Search starts one past the last holder; offset NumReq wraps back onto it.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NumReq; k++) begin
      logic [GrantW-1:0] cand;
      cand = last_q + GrantW'(k);
      if (!win_found && bus.ReqValid[cand]) begin
        winner    = cand;
        win_found = 1'b1;
      end
    end
  end

  assign sel_valid = bus.ReqValid[grant_q];

  always_ff @(posedge Wclk or negedge Wresetn) begin
    if (!Wresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GrantW'(NumReq - 1);
      burst_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    stall_d = stall_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = winner;
          burst_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!sel_valid) begin
          state_d = IDLE;
          last_d  = grant_q;
        end else if (bus.full) begin
          if (stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
          end
        end else begin
          push    = 1'b1;
          burst_d = burst_q + BurstW'(1);
          if (burst_q == LastBeat) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Push     = push;
  assign bus.DataIn   = req_slice[grant_q];
  assign bus.GrantId  = grant_q;
  assign bus.Busy     = (state_q == BURST);
  assign bus.StallCnt = stall_q;

endmodule

// File: tb/tb_afifo_write_arbiter.sv
// Self-checking bench: per-cycle vector tables plus a push-order scoreboard,
// with hand sequences for mid-burst reset and stall-counter saturation.
module tb_afifo_write_arbiter;

  localparam int DW = 3;
  localparam int NR = 4;
  localparam int MB = 4;

  typedef struct {
    logic [3:0]  valid;
    logic [11:0] data;
    logic        full;
    logic        exp_push;
    logic [1:0]  exp_grant;
    logic        exp_busy;
  } vec_t;

  logic Wclk;
  logic Wresetn;

  afifo_write_arbiter_if #(.DataSize(DW), .NumReq(NR)) bus ();

  afifo_write_arbiter #(.DataSize(DW), .NumReq(NR), .MaxBurst(MB)) dut (
    .Wclk    (Wclk),
    .Wresetn (Wresetn),
    .bus     (bus)
  );

  initial Wclk = 1'b0;
  always #5 Wclk = ~Wclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [2:0]  sb [$];
  vec_t        tbl [$];
  int          run_len [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [11:0] d, input logic f,
                              input logic p, input logic [1:0] g, input logic b);
    vec_t r;
    r.valid     = v;
    r.data      = d;
    r.full      = f;
    r.exp_push  = p;
    r.exp_grant = g;
    r.exp_busy  = b;
    return r;
  endfunction

  // Invariants and scoreboard pop, evaluated on the falling edge each cycle.
  task automatic monitor();
    logic [2:0] exp_d;
    if (bus.Push) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_push", 32'(bus.Push), 32'd0);
      end else begin
        exp_d = sb.pop_front();
        $display("push req %0d data %0h (expected %0h)", bus.GrantId, bus.DataIn, exp_d);
        check("sb_data", 32'(bus.DataIn), 32'(exp_d));
      end
    end
    check("push_while_full", 32'(bus.Push && bus.full), 32'd0);
    check("ready_onehot0", 32'($onehot0(bus.ReqReady)), 32'd1);
    check("ready_without_busy", 32'((|bus.ReqReady) && !bus.Busy), 32'd0);
    check("push_eq_ready", 32'(bus.Push), 32'(|bus.ReqReady));
    for (int i = 0; i < NR; i++) begin
      if (bus.ReqReady[i]) run_len[i]++;
      else run_len[i] = 0;
      check("ready_run_len", 32'(run_len[i] > MB), 32'd0);
    end
  endtask

  task automatic step();
    @(negedge Wclk);
    monitor();
    @(posedge Wclk);
    #1;
  endtask

  task automatic apply_row(input vec_t v, input string tag);
    logic [3:0] exp_ready;
    logic [2:0] exp_data;
    bus.ReqValid = v.valid;
    bus.ReqData  = v.data;
    bus.full     = v.full;
    exp_ready    = v.exp_push ? (4'b0001 << v.exp_grant) : 4'b0000;
    exp_data     = v.data[int'(v.exp_grant)*DW +: DW];
    if (v.exp_push) sb.push_back(exp_data);
    @(negedge Wclk);
    check({tag, "_push"},  32'(bus.Push),     32'(v.exp_push));
    check({tag, "_grant"}, 32'(bus.GrantId),  32'(v.exp_grant));
    check({tag, "_busy"},  32'(bus.Busy),     32'(v.exp_busy));
    check({tag, "_ready"}, 32'(bus.ReqReady), 32'(exp_ready));
    check({tag, "_dout"},  32'(bus.DataIn),   32'(exp_data));
    monitor();
    @(posedge Wclk);
    #1;
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) apply_row(tbl[i], $sformatf("%s%0d", tag, i));
    tbl.delete();
  endtask

  task automatic do_reset();
    bus.ReqValid = '0;
    bus.ReqData  = '0;
    bus.full     = 1'b0;
    Wresetn      = 1'b0;
    @(negedge Wclk);
    Wresetn = 1'b1;
    @(posedge Wclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_push"},  32'(bus.Push),     32'd0);
    check({tag, "_ready"}, 32'(bus.ReqReady), 32'd0);
    check({tag, "_busy"},  32'(bus.Busy),     32'd0);
    check({tag, "_grant"}, 32'(bus.GrantId),  32'd0);
    check({tag, "_stall"}, 32'(bus.StallCnt), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) run_len[i] = 0;
    Wresetn      = 1'b1;
    bus.ReqValid = '0;
    bus.ReqData  = '0;
    bus.full     = 1'b0;
    #2;
    Wresetn = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(negedge Wclk);
    Wresetn = 1'b1;
    @(posedge Wclk);
    #1;

    // Single requester: 4-push bursts separated by one arbitration cycle.
    tbl.push_back(mk(4'b0001, 12'd1, 1'b0, 1'b0, 2'd0, 1'b0));
    for (int d = 1; d <= 4; d++) tbl.push_back(mk(4'b0001, 12'(d), 1'b0, 1'b1, 2'd0, 1'b1));
    tbl.push_back(mk(4'b0001, 12'd5, 1'b0, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk(4'b0001, 12'd5, 1'b0, 1'b1, 2'd0, 1'b1));
    tbl.push_back(mk(4'b0001, 12'd6, 1'b0, 1'b1, 2'd0, 1'b1));
    tbl.push_back(mk(4'b0000, 12'd0, 1'b0, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk(4'b0000, 12'd0, 1'b0, 1'b0, 2'd0, 1'b0));
    run_table("single");
    check("single_stall", 32'(bus.StallCnt), 32'd0);

    // All requesters valid: grants 0,1,2,3,0 with a 5-cycle period.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      tbl.push_back(mk(4'hF, 12'h8D1, 1'b0, 1'b0, (g == 0) ? 2'd0 : 2'((g - 1) % NR), 1'b0));
      for (int b = 0; b < MB; b++) tbl.push_back(mk(4'hF, 12'h8D1, 1'b0, 1'b1, 2'(g % NR), 1'b1));
    end
    tbl.push_back(mk(4'h0, 12'h8D1, 1'b0, 1'b0, 2'd0, 1'b0));
    run_table("rr");

    // Requester 2 blocked by full for 7 cycles mid-burst, then finishes its 4 pushes.
    do_reset();
    tbl.push_back(mk(4'b0100, 12'h140, 1'b0, 1'b0, 2'd0, 1'b0));
    for (int b = 0; b < 2; b++) tbl.push_back(mk(4'b0100, 12'h140, 1'b0, 1'b1, 2'd2, 1'b1));
    for (int s = 0; s < 7; s++) tbl.push_back(mk(4'b0100, 12'h140, 1'b1, 1'b0, 2'd2, 1'b1));
    for (int b = 0; b < 2; b++) tbl.push_back(mk(4'b0100, 12'h140, 1'b0, 1'b1, 2'd2, 1'b1));
    tbl.push_back(mk(4'b0000, 12'h140, 1'b0, 1'b0, 2'd2, 1'b0));
    run_table("stall");
    check("stall_count", 32'(bus.StallCnt), 32'd7);

    // Reset lands in the middle of a requester-3 push.
    apply_row(mk(4'b1000, 12'hC00, 1'b0, 1'b0, 2'd2, 1'b0), "midrst_arb");
    #1;
    check("midrst_push_before", 32'(bus.Push),    32'd1);
    check("midrst_grant_before", 32'(bus.GrantId), 32'd3);
    check("midrst_data_before", 32'(bus.DataIn),  32'd6);
    Wresetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge Wclk);
    Wresetn = 1'b1;
    #1;
    check("post_rst_busy",  32'(bus.Busy),    32'd0);
    check("post_rst_grant", 32'(bus.GrantId), 32'd0);
    check("post_rst_push",  32'(bus.Push),    32'd0);
    @(posedge Wclk);
    #1;
    for (int b = 0; b < MB; b++) tbl.push_back(mk(4'b1000, 12'hC00, 1'b0, 1'b1, 2'd3, 1'b1));
    tbl.push_back(mk(4'b0000, 12'hC00, 1'b0, 1'b0, 2'd3, 1'b0));
    run_table("postrst");

    // Long stall: StallCnt must saturate at 16'hFFFF.
    do_reset();
    apply_row(mk(4'b0001, 12'd3, 1'b1, 1'b0, 2'd0, 1'b0), "sat_arb");
    for (int k = 0; k < 65534; k++) step();
    check("sat_fffe", 32'(bus.StallCnt), 32'hFFFE);
    check("sat_busy", 32'(bus.Busy),     32'd1);
    step();
    check("sat_ffff", 32'(bus.StallCnt), 32'hFFFF);
    for (int k = 0; k < 5; k++) step();
    check("sat_hold", 32'(bus.StallCnt), 32'hFFFF);
    check("sat_no_push", 32'(bus.Push),  32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
